warp_fetcher: RTL

- Per-warp instruction fetch stage, directly upstream of the warp decoder.
- While the warp scheduler holds a warp in WARP_FETCH, the block issues one program-memory read at the warp's PC and registers the returned 32-bit word.
- It holds that word stable on `instruction` through WARP_DECODE, where the decoder samples it.
- A timeout watchdog flags a hung program-memory controller.

---
 rtl/warp_fetcher_if.sv | 40 ++++
 rtl/warp_fetcher.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/warp_fetcher_if.sv
// Shared warp types and the program-memory read handshake used by warp_fetcher.
// The fetcher drives the request side (master); the memory controller is the slave.
package warp_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef logic [31:0] instruction_t;
endpackage

interface warp_fetcher_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_read_valid;
    logic [ADDR_WIDTH-1:0]  mem_read_address;
    logic                   mem_read_ready;
    logic [INSTR_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/warp_fetcher.sv
// Per-warp instruction fetch stage with a sticky timeout watchdog.
// Optional WARP_FETCHER_LAST_HIT_EN skips the memory read when pc repeats.
module warp_fetcher
    import warp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int INSTR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  warp_state_t            warp_state,
    input  logic [ADDR_WIDTH-1:0]  pc,
    warp_fetcher_if.master         mem,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [1:0]             fetcher_state,
    output logic                   fetch_error
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCHING = 2'd1,
        S_FETCHED  = 2'd2,
        S_ERROR    = 2'd3
    } fstate_e;

    fstate_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   hit;

`ifdef WARP_FETCHER_LAST_HIT_EN
    logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
    logic                   last_valid_q, last_valid_d;

    assign hit = last_valid_q && (pc == last_addr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef WARP_FETCHER_LAST_HIT_EN
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (warp_state == WARP_FETCH) begin
                    if (hit) begin
                        state_d = S_FETCHED;
                    end else begin
                        addr_d  = pc;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCHING;
                    end
                end
            end
            S_FETCHING: begin
                // Completion beats the watchdog when both land on one edge.
                if (valid_q && mem.mem_read_ready) begin
                    instr_d = mem.mem_read_data;
                    valid_d = 1'b0;
                    state_d = S_FETCHED;
`ifdef WARP_FETCHER_LAST_HIT_EN
                    last_addr_d  = addr_q;
                    last_valid_d = 1'b1;
`endif
                end else if (WDOG_EN && cnt_q == CNT_LAST) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCHED: begin
                if (warp_state == WARP_DECODE) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.mem_read_valid   = valid_q;
    assign mem.mem_read_address = addr_q;
    assign instruction          = instr_q;
    assign fetcher_state        = state_q;
    assign fetch_error          = err_q;

endmodule
